ita_scroll14: RTL
=================

# ita_scroll14

Scrolling text source and scan driver for the 12-digit, 14-segment display. Holds up to 16 character codes written by the host and maps each through a fixed 14-segment font. It time-multiplexes the visible 12-character window onto the digit-select and segment buses, and rotates the window through the message at a programmable frame rate. It sits directly upstream of the display pads and replaces hard-coded message banks with a writable, scrolling message.

## Interface
Parameters:
- `DIGITS`, 12: number of display digits, which is also the width of `sel`.
- `DEPTH`, 16: message buffer entries.
- `SCROLL_FRAMES`, 1024: completed scan frames per one-character scroll step; legal range ≥ 1.

Ports:
- `clk` input 1: single clock; every register is updated on its rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `wr_en` input 1: write strobe for the message buffer.
- `wr_addr` input 4: buffer entry index, 0..15.
- `wr_data` input 5: character code.
- `len_we` input 1: length write strobe.
- `len_data` input 5: message length; 0..16, values above 16 clamp to 16.
- `scroll_en` input 1: 1 = scrolling enabled, 0 = window offset frozen.
- `sel` output DIGITS: one-hot digit enable, registered.
- `segm` output 14: segment pattern for the selected digit, registered.
- `frame_start` output 1: 1-cycle pulse, registered, coincident with the output cycle that shows digit 0.

## Operation
- Character codes:
  - 0: blank.
  - 1..26: A..Z.
  - 27..31: blank.
- Font is the team's standard 14-segment table. Required checks:
  - A = 14'b11101111000000
  - E = 14'b10011110000000
  - S = 14'b10110111000000
  - D = 14'b11110000010010
  - blank = 14'b00000000000000
- Scan counter `d` runs 0..DIGITS-1 and advances every clock. It wraps from DIGITS-1 to 0; a wrap marks the end of a frame.
- Displayed index: `idx = (off + d) mod len`, computed without a divider. `off` < len always, and d < DIGITS, so use iterative compare/subtract or a wrapped pointer.
- Per cycle, the block registers:
  - `sel <= 1 << d`
  - `segm <= font(buf[idx])` when len ≠ 0; `segm <= 0` when len == 0.
- Frame counter `fc` counts completed frames while `scroll_en` = 1.
  - At a frame wrap with fc == SCROLL_FRAMES-1, the block sets fc to 0 and `off <= (off + 1 == len) ? 0 : off + 1`.
  - `off` therefore changes only at frame boundaries, so a frame is never torn.
  - With `scroll_en` = 0, fc and off hold their values.
- Message length shorter than DIGITS: the message repeats across the window, since idx wraps mod len.
- `len_we`:
  - Sets `len` from `len_data` (clamped) on the next edge.
  - Sets a pending flag. At the next frame start, off and fc reset to 0 and the flag clears.
  - Until then, idx uses the new len with the old off; if off ≥ new len, the index is forced to 0.
- `wr_en`: writes `buf[wr_addr] <= wr_data`. Display reads the pre-write value in the same cycle.

## Timing
- Reset, one edge with `rst` = 1, forces:
  - `sel` = 0, `segm` = 0, `frame_start` = 0.
  - d = 0, off = 0, fc = 0, len = 0, pending = 0.
  - all buffer entries = 0.
- `rst` takes priority over `wr_en` and `len_we` in the same cycle.
- First cycle after reset release: d = 0. The following edge registers `sel` = 1<<0.
- Latency is 1 cycle from counter state to outputs. Frame period is DIGITS clocks.
- Scroll step period is DIGITS × SCROLL_FRAMES clocks. The first output frame with the new off begins 1 cycle after the wrap edge.
- Reset asserted mid-frame: outputs go to 0 on that edge, and the scan restarts at digit 0 after release.
- Buffer write to an entry currently displayed: the old value is shown that cycle; the new value is shown from the next time that entry is selected.
- `wr_en` and `len_we` in the same cycle: both take effect independently.

## Test plan
- Reset, then write "SERENDIPIA" (codes 19,5,18,5,14,4,9,16,9,1) to entries 0..9, set len = 12 (entries 10..11 = 0), with scroll_en = 0. Over 12 cycles, `sel` must walk 0x001..0x800, and `segm` must show S, E, R, E, N, D, I, P, I, A, blank, blank. `frame_start` pulses with `sel` = 0x001.
- SCROLL_FRAMES = 2, len = 3 with buffer A, E, S, scroll_en = 1:
  - First two frames show A E S A E S…
  - The next two frames show E S A…
  - Then S A E…, then back to A E S.
- len = 0: `sel` still scans every digit, and `segm` = 0 for all 12 cycles.
- `len_we` with len_data = 20 during frame 5 with off = 2:
  - len reads back 16, pending = 1.
  - At the next frame start, off = 0 and fc = 0.
  - No output frame uses off ≥ len.
- Write entry 0 = E while the scan is on digit 0 with off = 0: the current cycle still registers the old pattern, and the next frame's digit 0 shows E.
- Assert `rst` at d = 7 with `wr_en` high: outputs are 0 on the next edge, the write is dropped (entry stays 0), and the scan restarts at `sel` = 0x001.

Source files
------------

// File: rtl/ita_scroll14_if.sv
// Host-write and scan-output bundle for the 14-segment scrolling display driver.
// Latency: none, signal container only.
// Backpressure: none; writes are fire-and-forget strobes, scan outputs free-run.
//
// Ports (via modports):
//   wr_en/wr_addr/wr_data   message buffer write
//   len_we/len_data         message length write (clamped by the driver)
//   scroll_en               1 = window rotates, 0 = window frozen
//   sel/segm/frame_start    registered one-hot digit, segment pattern, frame marker
interface ita_scroll14_if #(
    parameter int DIGITS = 12
);
    logic              wr_en;
    logic [3:0]        wr_addr;
    logic [4:0]        wr_data;
    logic              len_we;
    logic [4:0]        len_data;
    logic              scroll_en;
    logic [DIGITS-1:0] sel;
    logic [13:0]       segm;
    logic              frame_start;

    // Host side: drives the message and control, observes the scan.
    modport master (
        output wr_en, wr_addr, wr_data, len_we, len_data, scroll_en,
        input  sel, segm, frame_start
    );

    // Display driver side.
    modport slave (
        input  wr_en, wr_addr, wr_data, len_we, len_data, scroll_en,
        output sel, segm, frame_start
    );
endinterface

// File: rtl/ita_scroll14.sv
// Scrolling 16-entry message source and 12-digit 14-segment scan driver.
// Latency: 1 cycle from scan-counter state to registered sel/segm/frame_start.
// Backpressure: none; the scan advances every clock, host writes always accepted.
//
// Ports: clk, rst (sync, active-high); bus (ita_scroll14_if.slave) carrying the
// host write/length/scroll controls and the sel/segm/frame_start outputs.
module ita_scroll14 #(
    parameter int DIGITS        = 12,
    parameter int DEPTH         = 16,
    parameter int SCROLL_FRAMES = 1024
) (
    input  logic         clk,
    input  logic         rst,
    ita_scroll14_if.slave bus
);
    localparam int DW   = $clog2(DIGITS);
    localparam int AW   = $clog2(DEPTH);
    localparam int LW   = $clog2(DEPTH + 1);
    localparam int ACCW = $clog2(DEPTH + DIGITS);
    localparam int FCW  = (SCROLL_FRAMES > 1) ? $clog2(SCROLL_FRAMES) : 1;

    localparam logic [DW-1:0]     D_LAST  = DW'(DIGITS - 1);
    localparam logic [FCW-1:0]    FC_LAST = FCW'(SCROLL_FRAMES - 1);
    localparam logic [DIGITS-1:0] SEL_ONE = DIGITS'(1);

    logic [4:0]     msg_buf [DEPTH];
    logic [DW-1:0]  d;
    logic [AW-1:0]  off;
    logic [FCW-1:0] fc;
    logic [LW-1:0]  len;
    logic           pending;

    logic [ACCW-1:0] acc;
    logic [AW-1:0]   idx;
    logic            wrap;

    // Standard 14-segment font, bit order a b c d e f g1 g2 h j k l m n (MSB..LSB).
    function automatic logic [13:0] font14(input logic [4:0] code);
        case (code)
            5'd1:    font14 = 14'b11101111000000; // A
            5'd2:    font14 = 14'b11110001010010; // B
            5'd3:    font14 = 14'b10011100000000; // C
            5'd4:    font14 = 14'b11110000010010; // D
            5'd5:    font14 = 14'b10011110000000; // E
            5'd6:    font14 = 14'b10001110000000; // F
            5'd7:    font14 = 14'b10111101000000; // G
            5'd8:    font14 = 14'b01101111000000; // H
            5'd9:    font14 = 14'b10010000010010; // I
            5'd10:   font14 = 14'b01111000000000; // J
            5'd11:   font14 = 14'b00001110001100; // K
            5'd12:   font14 = 14'b00011100000000; // L
            5'd13:   font14 = 14'b01101100101000; // M
            5'd14:   font14 = 14'b01101100100100; // N
            5'd15:   font14 = 14'b11111100000000; // O
            5'd16:   font14 = 14'b11001111000000; // P
            5'd17:   font14 = 14'b11111100000100; // Q
            5'd18:   font14 = 14'b11001111000100; // R
            5'd19:   font14 = 14'b10110111000000; // S
            5'd20:   font14 = 14'b10000000010010; // T
            5'd21:   font14 = 14'b01111100000000; // U
            5'd22:   font14 = 14'b00001100001001; // V
            5'd23:   font14 = 14'b01101100000101; // W
            5'd24:   font14 = 14'b00000000101101; // X
            5'd25:   font14 = 14'b00000000101010; // Y
            5'd26:   font14 = 14'b10010000001001; // Z
            default: font14 = 14'b00000000000000; // blank (0, 27..31)
        endcase
    endfunction

    assign wrap = (d == D_LAST);

    // (off + d) mod len without a divider. Since off < len, the sum exceeds len
    // by at most DIGITS-1 multiples, so DIGITS compare/subtract stages suffice.
    // While a new length is pending, off may be stale and >= len; show entry 0.
    always_comb begin
        acc = ACCW'(off) + ACCW'(d);
        for (int i = 0; i < DIGITS; i++) begin
            if (acc >= ACCW'(len)) acc = acc - ACCW'(len);
        end
        if (len == '0 || LW'(off) >= len) idx = '0;
        else                              idx = acc[AW-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            d               <= '0;
            off             <= '0;
            fc              <= '0;
            len             <= '0;
            pending         <= 1'b0;
            bus.sel         <= '0;
            bus.segm        <= '0;
            bus.frame_start <= 1'b0;
            for (int i = 0; i < DEPTH; i++) msg_buf[i] <= '0;
        end else begin
            // Display path reads msg_buf before this edge's write lands.
            bus.sel         <= SEL_ONE << d;
            bus.segm        <= (len == '0) ? 14'd0 : font14(msg_buf[idx]);
            bus.frame_start <= (d == '0);

            if (bus.wr_en) msg_buf[bus.wr_addr] <= bus.wr_data;
            if (bus.len_we)
                len <= (LW'(bus.len_data) > LW'(DEPTH)) ? LW'(DEPTH) : LW'(bus.len_data);

            // off/fc only move on the frame wrap so a frame is never torn.
            if (wrap) begin
                d <= '0;
                if (pending) begin
                    off <= '0;
                    fc  <= '0;
                end else if (bus.scroll_en) begin
                    if (fc == FC_LAST) begin
                        fc  <= '0;
                        off <= (LW'(off) + LW'(1) >= len) ? '0 : off + AW'(1);
                    end else begin
                        fc <= fc + FCW'(1);
                    end
                end
            end else begin
                d <= d + DW'(1);
            end

            // A length write landing on the wrap edge stays pending for the next frame.
            pending <= bus.len_we | (pending & ~wrap);
        end
    end
endmodule
